// File: rtl/memoria_pkg.sv
// ----------------------------------------------------------------------------
// memoria_pkg
// Shared definitions for the operand memory: the clear/run state encoding and
// the default word/address widths used by the ALU top level.
// ----------------------------------------------------------------------------
package memoria_pkg;

    // Default operand geometry used by the ALU top level.
    localparam int MEM_DATA_W = 32;
    localparam int MEM_ADDR_W = 3;

    // CLEAR: post-reset sweep writing CLEAR_VAL to every row.
    // RUN:   normal operation, user reads/writes accepted.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage : memoria_pkg

// File: rtl/memoria_operandos_if.sv
// ----------------------------------------------------------------------------
// memoria_operandos_if
// Bus between the control unit (master) and the operand memory (slave).
//   we_i, waddr_i, wdata_i         write-back port
//   rd_req_i, raddr_a_i, raddr_b_i  dual read request
//   operador_a_o, operador_b_o     registered read data to the ALU
//   rd_valid_o                     one-cycle strobe, operands valid
//   ready_o                        clear finished, requests accepted
// ----------------------------------------------------------------------------
interface memoria_operandos_if
    import memoria_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W
);
    logic              we_i;
    logic [ADDR_W-1:0] waddr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              rd_req_i;
    logic [ADDR_W-1:0] raddr_a_i;
    logic [ADDR_W-1:0] raddr_b_i;
    logic [DATA_W-1:0] operador_a_o;
    logic [DATA_W-1:0] operador_b_o;
    logic              rd_valid_o;
    logic              ready_o;

    modport master (
        output we_i, waddr_i, wdata_i, rd_req_i, raddr_a_i, raddr_b_i,
        input  operador_a_o, operador_b_o, rd_valid_o, ready_o
    );

    modport slave (
        input  we_i, waddr_i, wdata_i, rd_req_i, raddr_a_i, raddr_b_i,
        output operador_a_o, operador_b_o, rd_valid_o, ready_o
    );

endinterface : memoria_operandos_if

// File: rtl/memoria_clear_fsm.sv
// ----------------------------------------------------------------------------
// memoria_clear_fsm
// Post-reset clear sequencer. After reset it sweeps rows 0..DEPTH-1, one per
// edge, then parks in RUN until the next reset.
//   clk_i, rst_ni   clock, synchronous active-low reset
//   o_clear_we      clear write strobe for the storage array
//   o_clear_addr    row being cleared
//   o_ready         1 once the sweep is done (RUN)
// ----------------------------------------------------------------------------
module memoria_clear_fsm
    import memoria_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic              o_clear_we,
    output logic [ADDR_W-1:0] o_clear_addr,
    output logic              o_ready
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_clear_we;
    logic              r_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= CLEAR;
            r_cnt      <= '0;
            r_clear_we <= 1'b1;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    // All-ones counter is the last row: terminal detect
                    // moves to RUN instead of letting the counter wrap.
                    if (&r_cnt) begin
                        r_state    <= RUN;
                        r_clear_we <= 1'b0;
                        r_ready    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RUN: begin
                    r_state    <= RUN;
                    r_clear_we <= 1'b0;
                    r_ready    <= 1'b1;
                end
                default: begin
                    r_state    <= CLEAR;
                    r_cnt      <= '0;
                    r_clear_we <= 1'b1;
                    r_ready    <= 1'b0;
                end
            endcase
        end
    end

    assign o_clear_we   = r_clear_we;
    assign o_clear_addr = r_cnt;
    assign o_ready      = r_ready;

endmodule : memoria_clear_fsm

// File: rtl/memoria_operandos.sv
// ----------------------------------------------------------------------------
// memoria_operandos
// Two-read, one-write operand memory feeding ALU operands A and B.
// Registered reads with a one-cycle valid strobe, write-first forwarding per
// port, and a self-clearing sweep after reset.
//   clk_i, rst_ni   clock, synchronous active-low reset
//   bus (slave)     write port, dual read request, operands, valid, ready
// ----------------------------------------------------------------------------
module memoria_operandos
    import memoria_pkg::*;
#(
    parameter int                DATA_W    = MEM_DATA_W,
    parameter int                ADDR_W    = MEM_ADDR_W,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    memoria_operandos_if.slave   bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic              w_clear_we;
    logic [ADDR_W-1:0] w_clear_addr;
    logic              w_ready;

    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_user_we;
    logic              w_rd_acc;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic              r_rd_valid;

    memoria_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .o_clear_we   (w_clear_we),
        .o_clear_addr (w_clear_addr),
        .o_ready      (w_ready)
    );

    // User traffic is only honoured in RUN.
    assign w_user_we = w_ready & bus.we_i;
    assign w_rd_acc  = w_ready & bus.rd_req_i;

    // Clear sweep owns the write port until ready; a reset edge writes nothing.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = bus.waddr_i;
        w_wdata = bus.wdata_i;
        if (rst_ni) begin
            if (w_clear_we) begin
                w_we    = 1'b1;
                w_waddr = w_clear_addr;
                w_wdata = CLEAR_VAL;
            end else begin
                w_we = w_user_we;
            end
        end
    end

    // NOTE: the storage array has no reset; the clear sweep initialises it,
    // which keeps it mappable onto RAM primitives.
    always_ff @(posedge clk_i) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Registered read ports; a same-cycle write to the read address is
    // forwarded so each port returns the new word (write-first).
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_op_a <= (w_user_we && bus.waddr_i == bus.raddr_a_i)
                          ? bus.wdata_i : r_mem[bus.raddr_a_i];
                r_op_b <= (w_user_we && bus.waddr_i == bus.raddr_b_i)
                          ? bus.wdata_i : r_mem[bus.raddr_b_i];
            end
        end
    end

    assign bus.operador_a_o = r_op_a;
    assign bus.operador_b_o = r_op_b;
    assign bus.rd_valid_o   = r_rd_valid;
    assign bus.ready_o      = w_ready;

endmodule : memoria_operandos

// File: tb/tb_memoria_operandos.sv
// ----------------------------------------------------------------------------
// tb_memoria_operandos
// Directed bench for memoria_operandos. Read requests push the hand-computed
// operand pair and its due cycle into a queue; a monitor pops and compares
// whenever rd_valid_o is high.
// ----------------------------------------------------------------------------
module tb_memoria_operandos;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        int                due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];

    memoria_operandos_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    memoria_operandos #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .CLEAR_VAL ('0)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stimulus changes and checks happen on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.we_i      = 1'b0;
        bus.waddr_i   = '0;
        bus.wdata_i   = '0;
        bus.rd_req_i  = 1'b0;
        bus.raddr_a_i = '0;
        bus.raddr_b_i = '0;
    endtask

    task automatic write(input int addr, input logic [DATA_W-1:0] data);
        bus.we_i    = 1'b1;
        bus.waddr_i = ADDR_W'(addr);
        bus.wdata_i = data;
        tick();
        bus.we_i    = 1'b0;
    endtask

    // Set up a read for the next edge and queue its expected result.
    task automatic req_read(input int ra, input int rb,
                            input logic [DATA_W-1:0] ea, input logic [DATA_W-1:0] eb);
        exp_t e;
        bus.rd_req_i  = 1'b1;
        bus.raddr_a_i = ADDR_W'(ra);
        bus.raddr_b_i = ADDR_W'(rb);
        e.a   = ea;
        e.b   = eb;
        e.due = cyc + 1;
        sb_q.push_back(e);
    endtask

    // Monitor: every valid strobe must match the oldest queued request,
    // arriving exactly one cycle after it was issued.
    always @(negedge clk) begin
        if (bus.rd_valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: rd_valid_o=1 with no request pending (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("op_a", bus.operador_a_o, e.a);
                check("op_b", bus.operador_b_o, e.b);
                check("latency", DATA_W'(cyc), DATA_W'(e.due));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle();
        rst_n = 1'b0;

        // Reset held for two edges.
        tick();
        tick();
        check("rst_ready", DATA_W'(bus.ready_o), 0);
        check("rst_valid", DATA_W'(bus.rd_valid_o), 0);
        check("rst_op_a", bus.operador_a_o, 0);
        check("rst_op_b", bus.operador_b_o, 0);

        // Release; requests during edges 2..5 of the clear must be ignored.
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            if (e >= 2 && e <= 5) begin
                bus.we_i      = 1'b1;
                bus.waddr_i   = 3'd3;
                bus.wdata_i   = 32'hFFFF_FFFF;
                bus.rd_req_i  = 1'b1;
                bus.raddr_a_i = 3'd3;
                bus.raddr_b_i = 3'd6;
            end else begin
                idle();
            end
            tick();
            check($sformatf("clear_ready_e%0d", e), DATA_W'(bus.ready_o), DATA_W'(e == 8));
        end
        check("clear_op_a_hold", bus.operador_a_o, 0);

        // Every row reads back zero after the clear.
        for (int i = 0; i < 8; i++) begin
            req_read(i, 7 - i, 32'h0, 32'h0);
            tick();
        end
        idle();
        tick();

        // Write then read; valid is a single-cycle strobe.
        write(0, 32'h350F_6992);
        req_read(0, 7, 32'h350F_6992, 32'h0);
        tick();
        idle();
        tick();
        check("strobe_drop", DATA_W'(bus.rd_valid_o), 0);
        check("hold_a", bus.operador_a_o, 32'h350F_6992);

        // Same-cycle write and read of row 3 on both ports: write-first.
        bus.we_i    = 1'b1;
        bus.waddr_i = 3'd3;
        bus.wdata_i = 32'hDEAD_BEEF;
        req_read(3, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        tick();
        idle();
        tick();

        // Back-to-back reads of rows 0,1,2.
        write(1, 32'h1111_2222);
        write(2, 32'h3333_4444);
        req_read(0, 2, 32'h350F_6992, 32'h3333_4444);
        tick();
        req_read(1, 1, 32'h1111_2222, 32'h1111_2222);
        tick();
        req_read(2, 0, 32'h3333_4444, 32'h350F_6992);
        tick();
        idle();
        tick();
        check("b2b_valid_drop", DATA_W'(bus.rd_valid_o), 0);
        check("b2b_hold_a", bus.operador_a_o, 32'h3333_4444);
        check("b2b_hold_b", bus.operador_b_o, 32'h350F_6992);
        tick();
        check("b2b_hold_a2", bus.operador_a_o, 32'h3333_4444);

        // Mid-run reset during a read: read and write both dropped.
        write(1, 32'hAAAA_5555);
        write(5, 32'h1234_5678);
        rst_n         = 1'b0;
        bus.rd_req_i  = 1'b1;
        bus.raddr_a_i = 3'd1;
        bus.raddr_b_i = 3'd5;
        bus.we_i      = 1'b1;
        bus.waddr_i   = 3'd2;
        bus.wdata_i   = 32'h5A5A_5A5A;
        tick();
        check("mid_rst_ready", DATA_W'(bus.ready_o), 0);
        check("mid_rst_valid", DATA_W'(bus.rd_valid_o), 0);
        check("mid_rst_op_a", bus.operador_a_o, 0);
        check("mid_rst_op_b", bus.operador_b_o, 0);
        idle();
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("reclear_ready_e%0d", e), DATA_W'(bus.ready_o), DATA_W'(e == 8));
        end
        req_read(1, 5, 32'h0, 32'h0);
        tick();
        req_read(2, 3, 32'h0, 32'h0);
        tick();
        idle();
        tick();
        tick();

        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d reads never returned, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_memoria_operandos

// File: doc/memoria_operandos.md
# memoria_operandos

Parametrised two-read, one-write operand memory feeding the ALU's A and B operand inputs. It replaces fixed, combinationally read operand ROMs with a clocked RAM that the datapath can write. It provides registered reads with a valid strobe, write-first forwarding, and a self-clearing sequence after reset. It sits between the control unit, which supplies addresses and the write-back port, and the ALU operand inputs.

## Interface
Parameters:
- DATA_W, 32, word width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W rows
- CLEAR_VAL, {DATA_W{1'b0}}, value written to every row by the post-reset clear

Ports:
- clk_i  in  1  single clock; all state changes on the rising edge
- rst_ni  in  1  synchronous, active-low reset, sampled on the rising edge of clk_i
- we_i  in  1  write enable
- waddr_i  in  ADDR_W  write address
- wdata_i  in  DATA_W  write data
- rd_req_i  in  1  read request for both ports
- raddr_a_i  in  ADDR_W  port A read address
- raddr_b_i  in  ADDR_W  port B read address
- operador_a_o  out  DATA_W  registered port A data
- operador_b_o  out  DATA_W  registered port B data
- rd_valid_o  out  1  one-cycle strobe; operands are valid
- ready_o  out  1  clear finished; requests accepted

## Operation
- State machine has two states: CLEAR and RUN.
  - Reset forces CLEAR with row counter = 0.
  - In CLEAR, each edge writes CLEAR_VAL to row[counter], then the counter increments.
  - On the edge that writes row DEPTH-1, the FSM moves to RUN.
  - RUN is held until the next reset.
- ready_o is 1 only in RUN.
- In CLEAR, we_i and rd_req_i are ignored: no write, no rd_valid_o, outputs hold.
- Writes in RUN: we_i=1 writes wdata_i to row[waddr_i] at the edge.
- Reads in RUN: rd_req_i=1 captures row[raddr_a_i] into operador_a_o and row[raddr_b_i] into operador_b_o. rd_valid_o=1 for the following cycle.
- Read-during-write to the same address in the same cycle is write-first: the port returns wdata_i. This applies to each port independently.
- Ports A and B may use the same address; both return the same word.
- operador_*_o hold their last captured value until the next accepted read.

## Timing
- Reset values: operador_a_o=0, operador_b_o=0, rd_valid_o=0, ready_o=0. Memory contents are not reset directly; the clear sequence overwrites them.
- Clear latency: ready_o rises after exactly DEPTH rising edges with rst_ni=1 (8 for the defaults).
- Read latency: 1 cycle from the request edge to data and rd_valid_o.
- Back-to-back reads: one per cycle, with rd_valid_o held high continuously.
- Write latency: the data is visible to a read request issued in the same cycle (forwarding) and in every later cycle.
- Reset mid-operation: any edge with rst_ni=0 returns the block to CLEAR, counter 0, all outputs at reset values. A pending read is dropped and a pending write is discarded.
- Counter is ADDR_W+1 bits wide or uses explicit terminal detect, so there is no wrap-around before the RUN transition.

## Structure
- Shared package memoria_pkg holds:
  - state enum {CLEAR, RUN}
  - default DATA_W and ADDR_W constants used by the ALU top level
- One sub-module: memoria_clear_fsm. It contains the state register and counter and outputs clear_we, clear_addr and ready.
- The top level muxes the clear write and the user write, and holds the storage array and output registers.

## Test plan
- Reset then release: rst_ni low 2 cycles, then high.
  - ready_o stays 0 for 8 edges and is 1 after the 8th.
  - Reading rows 0–7 then returns 0; rd_valid_o=0 throughout CLEAR.
- Write then read: write 32'h350F_6992 to row 0, then rd_req_i with A=0, B=7.
  - Next cycle: operador_a_o=32'h350F_6992, operador_b_o=0, rd_valid_o=1 for 1 cycle.
- Forwarding: same cycle, we_i to row 3 with 32'hDEAD_BEEF and rd_req_i with A=3, B=3.
  - Both outputs are 32'hDEAD_BEEF next cycle.
- Back-to-back reads of rows 0,1,2 on consecutive cycles.
  - rd_valid_o high 3 consecutive cycles with matching data; outputs hold after rd_req_i drops.
- Requests during CLEAR: we_i/rd_req_i asserted during cycles 2–5 of clear.
  - No rd_valid_o; after ready_o, every row reads 0.
- Mid-run reset: write nonzero data to rows 1 and 5, assert rst_ni low for 1 cycle during a read.
  - Outputs go to 0, ready_o goes to 0, and rises again after 8 edges.
  - Rows 1 and 5 then read 0.
